// File: rtl/sm3_cf_core.sv
// Iterative SM3 compression function: one round per clock with a sliding 16-word expansion window.
// Optional build macro SM3_CF_TWO_ROUNDS_EN evaluates two rounds per clock (33-cycle latency).
module sm3_cf_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         cf_start,
    input  logic [255:0] iv,
    input  logic [511:0] block,
    output logic [255:0] hash_out,
    output logic         cf_end
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

`ifdef SM3_CF_TWO_ROUNDS_EN
    localparam logic [5:0] J_STEP = 6'd2;
    localparam logic [5:0] LAST_J = 6'd62;
`else
    localparam logic [5:0] J_STEP = 6'd1;
    localparam logic [5:0] LAST_J = 6'd63;
`endif

    state_t       state;
    logic [255:0] v_reg;
    logic [255:0] st;
    logic [255:0] st_nxt;
    logic [511:0] win;
    logic [511:0] win_nxt;
    logic [5:0]   j;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
    endfunction

    // Window word k sits at bits [511-32k -: 32]; w0 is consumed first.
    function automatic logic [255:0] round_step(input logic [255:0] s,
                                                input logic [511:0] w,
                                                input logic [5:0]   jj);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2, w0, w4;
        {a, b, c, d, e, f, g, h} = s;
        w0  = w[511:480];
        w4  = w[383:352];
        tj  = (jj < 6'd16) ? rotl(32'h79cc4519, jj[4:0]) : rotl(32'h7a879d8a, jj[4:0]);
        a12 = rotl(a, 5'd12);
        ss1 = rotl(a12 + e + tj, 5'd7);
        ss2 = ss1 ^ a12;
        ff  = (jj < 6'd16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
        gg  = (jj < 6'd16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
        tt1 = ff + d + ss2 + (w0 ^ w4);
        tt2 = gg + h + ss1 + w0;
        return {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
    endfunction

    function automatic logic [511:0] expand(input logic [511:0] w);
        logic [31:0] w0, w3, w7, w10, w13, wn;
        w0  = w[511:480];
        w3  = w[415:384];
        w7  = w[287:256];
        w10 = w[191:160];
        w13 = w[95:64];
        wn  = p1(w0 ^ w7 ^ rotl(w13, 5'd15)) ^ rotl(w3, 5'd7) ^ w10;
        return {w[479:0], wn};
    endfunction

`ifdef SM3_CF_TWO_ROUNDS_EN
    logic [255:0] st_mid;
    logic [511:0] win_mid;

    // Second step of the pair sees the window already advanced by one word.
    always_comb begin
        st_mid  = round_step(st, win, j);
        win_mid = expand(win);
        st_nxt  = round_step(st_mid, win_mid, j + 6'd1);
        win_nxt = expand(win_mid);
    end
`else
    always_comb begin
        st_nxt  = round_step(st, win, j);
        win_nxt = expand(win);
    end
`endif

    // hash_out is written only in FINAL so it can be chained straight back into iv.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            v_reg    <= '0;
            st       <= '0;
            win      <= '0;
            j        <= '0;
            hash_out <= '0;
            cf_end   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cf_start && !cf_end) begin
                        v_reg <= iv;
                        st    <= iv;
                        win   <= block;
                        j     <= '0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= st_nxt;
                    win <= win_nxt;
                    j   <= j + J_STEP;
                    if (j == LAST_J) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    hash_out <= st ^ v_reg;
                    cf_end   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!cf_start) begin
                        cf_end <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_cf_core.sv
// Testbench for sm3_cf_core: array-based SM3 reference plus protocol model, checked every cycle.
// Honours SM3_CF_TWO_ROUNDS_EN for the expected latency.
module tb_sm3_cf_core;

`ifdef SM3_CF_TWO_ROUNDS_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 65;
`endif

    localparam logic [255:0] IV0 = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] EXP_ABC = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [511:0] BLK_ABCD = {16{32'h61626364}};
    localparam logic [511:0] BLK_PAD2 = {32'h80000000, 448'h0, 32'h00000200};
    localparam logic [255:0] EXP_ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cf_start = 1'b0;
    logic [255:0] iv = '0;
    logic [511:0] block = '0;
    logic [255:0] hash_out;
    logic         cf_end;

    int tests = 0;
    int fails = 0;

    sm3_cf_core dut (
        .clk      (clk),
        .reset    (reset),
        .cf_start (cf_start),
        .iv       (iv),
        .block    (block),
        .hash_out (hash_out),
        .cf_end   (cf_end)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] fp0(input logic [31:0] x);
        return x ^ rl(x, 9) ^ rl(x, 17);
    endfunction

    function automatic logic [31:0] fp1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // Textbook formulation: full W[0..67] expansion first, then 64 rounds.
    function automatic logic [255:0] sm3_model(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [68];
        logic [31:0] r [8];
        logic [31:0] t, ss1, ss2, ff, gg, tt1, tt2;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++)
            w[i] = fp1(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15)) ^ rl(w[i-13], 7) ^ w[i-6];
        for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
        for (int jj = 0; jj < 64; jj++) begin
            t   = (jj < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(r[0], 12) + r[4] + rl(t, jj % 32), 7);
            ss2 = ss1 ^ rl(r[0], 12);
            ff  = (jj < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
            gg  = (jj < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
            tt1 = ff + r[3] + ss2 + (w[jj] ^ w[jj+4]);
            tt2 = gg + r[7] + ss1 + w[jj];
            r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = fp0(tt2);
        end
        return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]} ^ v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Protocol model: a request accepted while idle completes LAT edges later.
    logic         m_busy = 1'b0;
    logic         m_end = 1'b0;
    logic [255:0] m_hash = '0;
    logic [255:0] m_pending = '0;
    int           m_cnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_end  <= 1'b0;
            m_hash <= '0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) begin
                m_busy <= 1'b0;
                m_end  <= 1'b1;
                m_hash <= m_pending;
            end
        end else if (m_end) begin
            if (!cf_start) m_end <= 1'b0;
        end else if (cf_start) begin
            m_busy    <= 1'b1;
            m_cnt     <= 0;
            m_pending <= sm3_model(iv, block);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("cyc_cf_end", {255'h0, cf_end}, {255'h0, m_end});
            checkOutput("cyc_hash_out", hash_out, m_hash);
        end
    end

    // Issues one request, waits (bounded) for cf_end, then releases cf_start.
    task automatic applyStimulus(input logic [255:0] v, input logic [511:0] b, input int drop_at,
                                 input bit scramble, output logic [255:0] result, output int latency);
        @(negedge clk);
        iv = v;
        block = b;
        cf_start = 1'b1;
        @(posedge clk);
        latency = 0;
        while (latency < 200) begin
            @(negedge clk);
            if (scramble && latency == 0) begin
                iv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                for (int k = 0; k < 16; k++) block[511 - 32*k -: 32] = $urandom;
            end
            if (drop_at >= 0 && latency == drop_at) cf_start = 1'b0;
            if (cf_end) break;
            @(posedge clk);
            latency++;
        end
        if (!cf_end) checkOutput("cf_end_timeout", 256'h0, 256'h1);
        result = hash_out;
        @(negedge clk);
        cf_start = 1'b0;
    endtask

    logic [255:0] res;
    logic [255:0] res1;
    int           lat;

    initial begin
        checkOutput("model_abc", sm3_model(IV0, BLK_ABC), EXP_ABC);
        checkOutput("model_chain", sm3_model(sm3_model(IV0, BLK_ABCD), BLK_PAD2), EXP_ABCD);

        #2 reset = 1'b0;
        #1;
        checkOutput("reset_hash_out", hash_out, 256'h0);
        checkOutput("reset_cf_end", {255'h0, cf_end}, 256'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(IV0, BLK_ABC, -1, 1'b0, res, lat);
        checkOutput("single_hash", res, EXP_ABC);
        checkOutput("single_latency", 256'(lat), 256'(LAT));

        applyStimulus(IV0, BLK_ABCD, -1, 1'b0, res1, lat);
        applyStimulus(res1, BLK_PAD2, -1, 1'b0, res, lat);
        checkOutput("chain_hash", res, EXP_ABCD);
        checkOutput("chain_latency", 256'(lat), 256'(LAT));

        applyStimulus(IV0, BLK_ABC, -1, 1'b1, res, lat);
        checkOutput("capture_hash", res, EXP_ABC);

        applyStimulus(IV0, BLK_ABC, 10, 1'b0, res, lat);
        checkOutput("early_hash", res, EXP_ABC);
        checkOutput("early_latency", 256'(lat), 256'(LAT));
        checkOutput("early_pulse_end", {255'h0, cf_end}, 256'h0);
        @(negedge clk);
        checkOutput("early_hold_hash", hash_out, EXP_ABC);

        applyStimulus(IV0, BLK_ABCD, -1, 1'b0, res, lat);
        checkOutput("turnaround_latency", 256'(lat), 256'(LAT));

        @(negedge clk);
        iv = IV0;
        block = BLK_PAD2;
        cf_start = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cf_start = 1'b0;
        #1;
        checkOutput("midreset_hash_out", hash_out, 256'h0);
        checkOutput("midreset_cf_end", {255'h0, cf_end}, 256'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(IV0, BLK_ABC, -1, 1'b0, res, lat);
        checkOutput("after_reset_hash", res, EXP_ABC);
        checkOutput("after_reset_latency", 256'(lat), 256'(LAT));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
